pim_cfu: RTL and testbench

- Processing-in-memory custom function unit on the CPU CFU command/response bus.
- Holds a PDEPTH x PWIDTH bit-cell array with word read and word write commands.
- Performs bit-serial in-memory MAC: per-column popcount of selected rows (ADC model), shifted and accumulated across successive MAC commands.

---
 rtl/pim_cfu_if.sv | 32 +++
 rtl/pim_cfu.sv | 133 +++++++++++++
 tb/tb_pim_cfu.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/pim_cfu_if.sv
// CFU command/response bus between the CPU and the PIM unit.
interface pim_cfu_if #(
    parameter int AWIDTH = 10,
    parameter int PWIDTH = 32,
    parameter int DWIDTH = 32
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic [AWIDTH-1:0] cmd_payload_function_id;
    logic [PWIDTH-1:0] cmd_payload_inputs_0;
    logic [PWIDTH-1:0] cmd_payload_inputs_1;
    logic              rsp_valid;
    logic              rsp_ready;
    logic              rsp_payload_response_ok;
    logic [DWIDTH-1:0] rsp_payload_outputs_0;

    modport master (
        output cmd_valid, cmd_payload_function_id,
        output cmd_payload_inputs_0, cmd_payload_inputs_1,
        output rsp_ready,
        input  cmd_ready, rsp_valid,
        input  rsp_payload_response_ok, rsp_payload_outputs_0
    );

    modport slave (
        input  cmd_valid, cmd_payload_function_id,
        input  cmd_payload_inputs_0, cmd_payload_inputs_1,
        input  rsp_ready,
        output cmd_ready, rsp_valid,
        output rsp_payload_response_ok, rsp_payload_outputs_0
    );
endinterface

// File: rtl/pim_cfu.sv
// PIM CFU: bit-cell array with word read/write and bit-serial popcount MAC.
// Optional CFU_RSP_HANDSHAKE_EN holds the response until rsp_ready.
module pim_cfu #(
    parameter logic [31:0] PIM_ADDR_BEGIN = 32'h000,
    parameter int DWIDTH = 32,
    parameter int AWIDTH = 10,
    parameter int PWIDTH = 32,
    parameter int PDEPTH = 1 << AWIDTH
) (
    input logic      clk,
    input logic      reset,
    pim_cfu_if.slave bus
);
    localparam int CWIDTH = AWIDTH + 1;

    typedef enum logic [1:0] {IDLE, MAC_EVAL, RESP} state_t;

    state_t state, state_nxt;

    logic [PWIDTH-1:0] mem [PDEPTH];
    logic [PDEPTH-1:0] rwl;
    logic [PDEPTH-1:0] rwl_sel;
    logic [31:0]       acc [PWIDTH];
    logic [31:0]       acc_nxt [PWIDTH];
    logic [CWIDTH-1:0] adc [PWIDTH];
    logic [31:0]       acc_sum;
    logic [4:0]        shift_cnt;
    logic [DWIDTH-1:0] outputs;

    logic              accept;
    logic              is_read;
    logic              is_write;
    logic              is_mac;
    logic [AWIDTH-1:0] row;
    logic [PWIDTH-1:0] addr_off;
    logic [PWIDTH-1:0] in0;

    assign in0      = bus.cmd_payload_inputs_0;
    assign addr_off = bus.cmd_payload_inputs_1 - PWIDTH'(PIM_ADDR_BEGIN);
    assign row      = addr_off[AWIDTH-1:0];
    assign is_read  = bus.cmd_payload_function_id[1:0] == 2'b00;
    assign is_write = bus.cmd_payload_function_id[1:0] == 2'b01;
    assign is_mac   = bus.cmd_payload_function_id[1];
    assign accept   = bus.cmd_valid & bus.cmd_ready;

`ifdef CFU_RSP_HANDSHAKE_EN
    logic unused_bits;
    assign unused_bits = ^{bus.cmd_payload_function_id[AWIDTH-1:2],
                           addr_off[PWIDTH-1:AWIDTH]};
`else
    logic unused_bits;
    assign unused_bits = ^{bus.rsp_ready,
                           bus.cmd_payload_function_id[AWIDTH-1:2],
                           addr_off[PWIDTH-1:AWIDTH]};
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:     if (accept) state_nxt = is_mac ? MAC_EVAL : RESP;
            MAC_EVAL: state_nxt = RESP;
`ifdef CFU_RSP_HANDSHAKE_EN
            RESP:     if (bus.rsp_ready) state_nxt = IDLE;
`else
            RESP:     state_nxt = IDLE;
`endif
            default:  state_nxt = IDLE;
        endcase
    end

    always_comb begin
        bus.cmd_ready = state == IDLE;
        bus.rsp_valid = state == RESP;
    end

    assign bus.rsp_payload_response_ok = reset;
    assign bus.rsp_payload_outputs_0   = outputs;

    // Word lines for a MAC window starting at row, wrapping past the top
    always_comb begin
        rwl_sel = '0;
        for (int i = 0; i < PWIDTH; i++)
            rwl_sel[row + AWIDTH'(i)] = in0[i];
    end

    always_comb begin
        acc_sum = '0;
        for (int j = 0; j < PWIDTH; j++) begin
            adc[j] = '0;
            for (int k = 0; k < PDEPTH; k++)
                adc[j] = adc[j] + CWIDTH'(mem[k][j] & rwl[k]);
            if (shift_cnt == 5'd0)
                acc_nxt[j] = 32'(adc[j]);
            else
                acc_nxt[j] = acc[j] + (32'(adc[j]) << shift_cnt);
            acc_sum = acc_sum + acc_nxt[j];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int k = 0; k < PDEPTH; k++) mem[k] <= '0;
            for (int j = 0; j < PWIDTH; j++) acc[j] <= '0;
            rwl       <= '0;
            shift_cnt <= '0;
            outputs   <= '0;
        end else if (accept) begin
            unique case (1'b1)
                is_mac: rwl <= rwl_sel;
                is_write: begin
                    mem[row]  <= in0;
                    outputs   <= DWIDTH'(in0);
                    shift_cnt <= '0;
                    for (int j = 0; j < PWIDTH; j++) acc[j] <= '0;
                end
                is_read: begin
                    outputs   <= DWIDTH'(mem[row]);
                    shift_cnt <= '0;
                    for (int j = 0; j < PWIDTH; j++) acc[j] <= '0;
                end
            endcase
        end else if (state == MAC_EVAL) begin
            for (int j = 0; j < PWIDTH; j++) acc[j] <= acc_nxt[j];
            outputs   <= DWIDTH'(acc_sum);
            shift_cnt <= shift_cnt + 5'd1;
        end
    end
endmodule

// File: tb/tb_pim_cfu.sv
// Directed bench for pim_cfu: read/write, MAC accumulation, abort, wrap.
module tb_pim_cfu;
    logic clk;
    logic reset;
    int   checks;
    int   failures;

    pim_cfu_if #(.AWIDTH(10), .PWIDTH(32), .DWIDTH(32)) bus ();

    pim_cfu dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic do_cmd(input string tag, input logic [1:0] op,
                          input logic [31:0] in0, input logic [31:0] in1,
                          input int exp_lat, input logic [31:0] exp_out);
        int waitc;
        int lat;
        @(negedge clk);
        bus.cmd_valid = 1'b1;
        bus.cmd_payload_function_id = {8'h00, op};
        bus.cmd_payload_inputs_0 = in0;
        bus.cmd_payload_inputs_1 = in1;
        waitc = 0;
        while (!bus.cmd_ready && waitc < 20) begin
            @(negedge clk);
            waitc++;
        end
        if (!bus.cmd_ready) begin
            check({tag, "_accept"}, 32'd0, 32'd1);
            bus.cmd_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1 bus.cmd_valid = 1'b0;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!bus.rsp_valid && lat < 10);
        check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
        check({tag, "_out"}, bus.rsp_payload_outputs_0, exp_out);
        check({tag, "_ok"}, 32'(bus.rsp_payload_response_ok), 32'd1);
        @(negedge clk);
        check({tag, "_pulse"}, 32'(bus.rsp_valid), 32'd0);
    endtask

    initial begin
        int acc_n;
        int rsp_n;
        checks   = 0;
        failures = 0;
        reset    = 1'b1;
        bus.cmd_valid = 1'b0;
        bus.cmd_payload_function_id = '0;
        bus.cmd_payload_inputs_0 = '0;
        bus.cmd_payload_inputs_1 = '0;
        bus.rsp_ready = 1'b1;

        #2 reset = 1'b0;
        #1;
        check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check("rst_cmd_ready", 32'(bus.cmd_ready), 32'd1);
        check("rst_out", bus.rsp_payload_outputs_0, 32'd0);
        check("rst_ok", 32'(bus.rsp_payload_response_ok), 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b1;

        do_cmd("rd7", 2'b00, 32'h0, 32'd7, 1, 32'h0);
        do_cmd("wr5", 2'b01, 32'hDEADBEEF, 32'd5, 1, 32'hDEADBEEF);
        do_cmd("rd5", 2'b00, 32'h0, 32'd5, 1, 32'hDEADBEEF);
        do_cmd("wrwrap", 2'b01, 32'h12345678, 32'h7FF, 1, 32'h12345678);
        do_cmd("rdwrap", 2'b00, 32'h0, 32'h3FF, 1, 32'h12345678);

        do_cmd("wr0", 2'b01, 32'h3, 32'd0, 1, 32'h3);
        do_cmd("wr1", 2'b01, 32'h1, 32'd1, 1, 32'h1);
        do_cmd("mac1", 2'b10, 32'h3, 32'd0, 2, 32'd3);
        do_cmd("mac2", 2'b10, 32'h3, 32'd0, 2, 32'd9);
        do_cmd("mac3", 2'b11, 32'h3, 32'd0, 2, 32'd21);
        do_cmd("rd5b", 2'b00, 32'h0, 32'd5, 1, 32'hDEADBEEF);
        do_cmd("mac_clr", 2'b10, 32'h3, 32'd0, 2, 32'd3);

        @(negedge clk);
        bus.cmd_valid = 1'b1;
        bus.cmd_payload_function_id = 10'd2;
        bus.cmd_payload_inputs_0 = 32'h3;
        bus.cmd_payload_inputs_1 = 32'd0;
        @(posedge clk);
        #1 bus.cmd_valid = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("abort_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check("abort_out", bus.rsp_payload_outputs_0, 32'd0);
        check("abort_ok", 32'(bus.rsp_payload_response_ok), 32'd0);
        check("abort_ready", 32'(bus.cmd_ready), 32'd1);
        rsp_n = 0;
        repeat (2) begin
            @(negedge clk);
            if (bus.rsp_valid) rsp_n++;
        end
        reset = 1'b1;
        repeat (3) begin
            @(negedge clk);
            if (bus.rsp_valid) rsp_n++;
        end
        check("abort_no_rsp", 32'(rsp_n), 32'd0);
        do_cmd("rd0_post", 2'b00, 32'h0, 32'd0, 1, 32'h0);

        do_cmd("wrtop", 2'b01, 32'h1, 32'h3FF, 1, 32'h1);
        do_cmd("wrbot", 2'b01, 32'h1, 32'd0, 1, 32'h1);
        do_cmd("macwrap", 2'b10, 32'h3, 32'h3FF, 2, 32'd2);

        @(negedge clk);
        bus.cmd_valid = 1'b1;
        bus.cmd_payload_function_id = 10'd0;
        bus.cmd_payload_inputs_0 = 32'h0;
        bus.cmd_payload_inputs_1 = 32'h3FF;
        acc_n = 0;
        rsp_n = 0;
        for (int i = 0; i < 12; i++) begin
            if (bus.cmd_ready) acc_n++;
            if (bus.rsp_valid) rsp_n++;
            if (i < 11) @(negedge clk);
        end
        bus.cmd_valid = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (bus.rsp_valid) rsp_n++;
        end
        check("b2b_accepts", 32'(acc_n), 32'd6);
        check("b2b_rsps", 32'(rsp_n), 32'd6);
        check("b2b_out", bus.rsp_payload_outputs_0, 32'h1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
